// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
//   Bundles the byte-stream handshake and the instruction-memory write port
//   of the program loader.
//
//   Parameter:
//     ADDR_W    instruction-memory address width
//
//   Signals:
//     rx_data   stream byte                    (source -> loader)
//     rx_valid  rx_data valid                  (source -> loader)
//     rx_ready  loader accepts byte            (loader -> source)
//     mem_we    instruction-memory write strobe (loader -> memory)
//     mem_addr  write address                  (loader -> memory)
//     mem_data  write data {W_HI, W_LO}        (loader -> memory)
//
//   Modports:
//     master    byte source / memory side (testbench, UART front-end)
//     slave     the loader itself
// ---------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Writer side of the instruction memory. Accepts a framed byte stream
//   (valid/ready), packs big-endian 16-bit words and writes them to
//   consecutive addresses starting at 0. The CPU is held in reset until a
//   frame has loaded cleanly.
//
//   Frame: SYNC_BYTE, LEN_HI, LEN_LO, {W_HI, W_LO} x LEN, [CSUM]
//
//   Configuration macro:
//     CHECKSUM_EN  when defined, a trailing CSUM byte (XOR of every byte
//                  from LEN_HI through the last W_LO) is checked; a mismatch
//                  rejects the frame. When undefined there is no CSUM byte
//                  and no checksum register.
//
//   Parameters:
//     ADDR_W     instruction-memory address width
//     MAX_WORDS  largest legal LEN (must be <= 2**ADDR_W)
//     SYNC_BYTE  frame start marker
//
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        slave side of prog_loader_if (byte stream + memory write)
//     cpu_hold   1 = CPU core held in reset (registered)
//     done       last frame loaded OK (level)
//     err        last frame rejected (level)
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int         ADDR_W    = 8,
    parameter int         MAX_WORDS = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
`ifdef CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len;
    logic [15:0] cnt;

    logic        xfer;
    logic        is_sync;
    logic [15:0] len_full;
    logic [15:0] cnt_inc;
    logic        len_bad;
    logic        last_word;

    assign xfer      = bus.rx_valid & bus.rx_ready;
    assign is_sync   = (bus.rx_data == SYNC_BYTE);
    // LEN as it will be once the LEN_LO byte currently on the bus is taken
    assign len_full  = {len[15:8], bus.rx_data};
    assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);
    assign cnt_inc   = cnt + 16'd1;
    assign last_word = (cnt_inc == len);

`ifdef CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (xfer) begin
            case (state)
                S_IDLE, S_DONE, S_ERR: if (is_sync) csum <= '0;
                S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: csum <= csum ^ bus.rx_data;
                default: ;
            endcase
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            // SYNC restarts from any resting state; other bytes are dropped
            S_IDLE, S_DONE, S_ERR: if (xfer && is_sync) state_nxt = S_LEN_HI;
            S_LEN_HI:  if (xfer) state_nxt = S_LEN_LO;
            S_LEN_LO:  if (xfer) state_nxt = len_bad ? S_ERR : S_DATA_HI;
            S_DATA_HI: if (xfer) state_nxt = S_DATA_LO;
            S_DATA_LO: if (xfer) state_nxt = S_WRITE;
`ifdef CHECKSUM_EN
            S_WRITE:   state_nxt = last_word ? S_CSUM : S_DATA_HI;
            S_CSUM:    if (xfer) state_nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
`else
            S_WRITE:   state_nxt = last_word ? S_DONE : S_DATA_HI;
`endif
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they switch on the
    // entering edge and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            bus.rx_ready <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            cnt          <= '0;
            len          <= '0;
        end else begin
            state        <= state_nxt;
            bus.rx_ready <= (state_nxt != S_WRITE);
            bus.mem_we   <= (state_nxt == S_WRITE);
            cpu_hold     <= (state_nxt != S_DONE);
            done         <= (state_nxt == S_DONE);
            err          <= (state_nxt == S_ERR);
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (xfer && is_sync) begin
                        cnt          <= '0;
                        bus.mem_addr <= '0;
                    end
                end
                S_LEN_HI:  if (xfer) len[15:8] <= bus.rx_data;
                S_LEN_LO:  if (xfer) len[7:0] <= bus.rx_data;
                S_DATA_HI: if (xfer) bus.mem_data[15:8] <= bus.rx_data;
                S_DATA_LO: if (xfer) bus.mem_data[7:0] <= bus.rx_data;
                // address/data stay stable through the strobe, then advance
                S_WRITE: begin
                    bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                    cnt          <= cnt_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int         ADDR_W    = 8;
    localparam int         MAX_WORDS = 256;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam int         ST_HOLD   = 0;
    localparam int         ST_DONE   = 1;
    localparam int         ST_ERR    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_hold;
    logic done;
    logic err;

    int total = 0;
    int bad   = 0;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(
        .ADDR_W   (ADDR_W),
        .MAX_WORDS(MAX_WORDS),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cpu_hold(cpu_hold),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // write log and ready/strobe relation, observed at every rising edge
    logic [23:0] wlog [$];
    int          hs_viol = 0;
    bit          armed   = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            armed = 1'b0;
        end else begin
            if (armed && (bus.rx_ready == bus.mem_we)) hs_viol++;
            if (bus.mem_we) wlog.push_back({bus.mem_addr, bus.mem_data});
            armed = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame-level parse) ----------------
    logic [7:0]  stream [$];
    logic [23:0] exp_w  [$];
    int          exp_st;

    function automatic logic [7:0] csum_after_sync();
        logic [7:0] c = 8'h00;
        bit seen = 1'b0;
        foreach (stream[k]) begin
            if (seen) c ^= stream[k];
            else if (stream[k] == SYNC) seen = 1'b1;
        end
        return c;
    endfunction

    function automatic void model_run();
        int i = 0;
        int n = stream.size();
        int len;
        logic [7:0] cs;
        bit partial;
        exp_w.delete();
        exp_st = ST_HOLD;
        while (i < n) begin
            if (stream[i] != SYNC) begin
                i++;
                continue;
            end
            exp_st = ST_HOLD;
            if (i + 2 >= n) break;
            len = {stream[i+1], stream[i+2]};
            cs  = stream[i+1] ^ stream[i+2];
            i  += 3;
            if (len == 0 || len > MAX_WORDS) begin
                exp_st = ST_ERR;
                continue;
            end
            partial = 1'b0;
            for (int k = 0; k < len; k++) begin
                if (i + 1 < n) begin
                    exp_w.push_back({8'(k), stream[i], stream[i+1]});
                    cs ^= stream[i] ^ stream[i+1];
                    i  += 2;
                end else begin
                    partial = 1'b1;
                    break;
                end
            end
            if (partial) break;
`ifdef CHECKSUM_EN
            if (i >= n) break;
            exp_st = (stream[i] == cs) ? ST_DONE : ST_ERR;
            i++;
`else
            exp_st = ST_DONE;
`endif
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        bus.rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            acc = bus.rx_ready;
            #1;
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("xfer_timeout", 32'd0, 32'd1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_stream(input int gap_max);
        foreach (stream[k]) send_byte(stream[k], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        wlog.delete();
    endtask

    task automatic check_status(input string tag, input int st);
        chk({tag, ".done"}, done, (st == ST_DONE));
        chk({tag, ".err"}, err, (st == ST_ERR));
        chk({tag, ".hold"}, cpu_hold, (st != ST_DONE));
    endtask

    task automatic compare_log(input string tag);
        chk({tag, ".nwrites"}, wlog.size(), exp_w.size());
        for (int k = 0; k < wlog.size() && k < exp_w.size(); k++)
            chk($sformatf("%s.w%0d", tag, k), wlog[k], exp_w[k]);
    endtask

    task automatic gen_random(input int nframes);
        logic [7:0] b;
        int len;
        int r;
        logic [7:0] cs;
        stream.delete();
        for (int f = 0; f < nframes; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                do b = 8'($urandom); while (b == SYNC);
                stream.push_back(b);
            end
            stream.push_back(SYNC);
            r = int'($urandom_range(0, 9));
            if (r == 0)      len = 0;
            else if (r == 1) len = MAX_WORDS + 1 + int'($urandom_range(0, 3));
            else             len = int'($urandom_range(1, 8));
            stream.push_back(8'(len >> 8));
            stream.push_back(8'(len));
            if (len == 0 || len > MAX_WORDS) continue;
            cs = 8'(len >> 8) ^ 8'(len);
            for (int j = 0; j < 2 * len; j++) begin
                b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
                stream.push_back(b);
                cs ^= b;
            end
`ifdef CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
            stream.push_back(cs);
`endif
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic [63:0] bytes;     // right-aligned, first byte most significant
        int          nb;
        bit          add_csum;  // append the correct CSUM when enabled
        int          exp_n;
        logic [23:0] exp_first;
        logic [23:0] exp_last;
        int          exp_st;
    } vec_t;

    vec_t vecs [$];

    initial begin
        vec_t v;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        vecs.push_back('{"two_words", 64'hA5_00_02_12_34_AB_CD, 7, 1'b1, 2, 24'h00_1234, 24'h01_ABCD, ST_DONE});
        vecs.push_back('{"len_zero", 64'hA5_00_00, 3, 1'b0, 0, 24'h0, 24'h0, ST_ERR});
        vecs.push_back('{"len_257", 64'hA5_01_01, 3, 1'b0, 0, 24'h0, 24'h0, ST_ERR});
        vecs.push_back('{"junk_first", 64'h11_22_A5_00_01_00_01, 7, 1'b1, 1, 24'h00_0001, 24'h00_0001, ST_DONE});
        vecs.push_back('{"sync_payload", 64'hA5_00_01_A5_A5, 5, 1'b1, 1, 24'h00_A5A5, 24'h00_A5A5, ST_DONE});

        // reset values while reset is held
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst.rx_ready", bus.rx_ready, 0);
        chk("rst.mem_we", bus.mem_we, 0);
        chk("rst.mem_addr", bus.mem_addr, 0);
        chk("rst.mem_data", bus.mem_data, 0);
        check_status("rst", ST_HOLD);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.ready_after_release", bus.rx_ready, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_reset();
            stream.delete();
            for (int k = 0; k < v.nb; k++) stream.push_back(v.bytes[(v.nb-1-k)*8 +: 8]);
`ifdef CHECKSUM_EN
            if (v.add_csum) stream.push_back(csum_after_sync());
`endif
            run_stream(0);
            chk({v.name, ".nwrites"}, wlog.size(), v.exp_n);
            if (v.exp_n > 0 && wlog.size() > 0) begin
                chk({v.name, ".first"}, wlog[0], v.exp_first);
                chk({v.name, ".last"}, wlog[wlog.size()-1], v.exp_last);
            end
            check_status(v.name, v.exp_st);
        end

        // restart from ERR and from DONE: flags change on the SYNC edge
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h00};
        run_stream(0);
        check_status("err_frame", ST_ERR);
        send_byte(SYNC, 0);
        check_status("sync_from_err", ST_HOLD);
        stream = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
`ifdef CHECKSUM_EN
        stream.push_back(csum_after_sync());
`endif
        void'(stream.pop_front());
        run_stream(1);
        check_status("reload", ST_DONE);
        chk("reload.nwrites", wlog.size(), 1);
        if (wlog.size() > 0) chk("reload.w0", wlog[0], 24'h00_1234);
        send_byte(SYNC, 0);
        check_status("sync_from_done", ST_HOLD);

`ifdef CHECKSUM_EN
        // bad checksum keeps the written word, then a clean resend succeeds
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'hFF};
        run_stream(0);
        check_status("csum_bad", ST_ERR);
        chk("csum_bad.nwrites", wlog.size(), 1);
        stream = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
        run_stream(0);
        check_status("csum_good", ST_DONE);
        chk("csum_good.nwrites", wlog.size(), 2);
        if (wlog.size() > 1) chk("csum_good.w1", wlog[1], 24'h00_0001);
`endif

        // asynchronous reset mid-cycle after a completed load
        bus.rx_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst.rx_ready", bus.rx_ready, 0);
        chk("async_rst.mem_addr", bus.mem_addr, 0);
        chk("async_rst.mem_data", bus.mem_data, 0);
        check_status("async_rst", ST_HOLD);

        // reset after the 2nd of 4 words, then a full frame from address 0
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22};
        foreach (stream[k]) send_byte(stream[k], 0);
        for (int n = 0; n < 10 && wlog.size() < 2; n++) begin @(posedge clk); #1; end
        chk("midrst.writes_before", wlog.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("midrst", ST_HOLD);
        chk("midrst.mem_we", bus.mem_we, 0);
        chk("midrst.mem_addr", bus.mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst.ready", bus.rx_ready, 1);
        wlog.delete();
        gen_random(1);
        stream = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`ifdef CHECKSUM_EN
        stream.push_back(csum_after_sync());
`endif
        model_run();
        run_stream(2);
        compare_log("midrst_reload");
        check_status("midrst_reload", exp_st);

        // randomized multi-frame streams with random valid gaps
        for (int r = 0; r < 6; r++) begin
            do_reset();
            gen_random(int'($urandom_range(2, 5)));
            model_run();
            run_stream(3);
            compare_log($sformatf("rand%0d", r));
            check_status($sformatf("rand%0d", r), exp_st);
        end

        // largest frame: 256 words, last write at address FF
        do_reset();
        stream.delete();
        stream.push_back(SYNC);
        stream.push_back(8'h01);
        stream.push_back(8'h00);
        for (int j = 0; j < 512; j++) stream.push_back(8'($urandom));
`ifdef CHECKSUM_EN
        stream.push_back(csum_after_sync());
`endif
        model_run();
        run_stream(2);
        compare_log("len256");
        check_status("len256", ST_DONE);
        if (wlog.size() > 0) chk("len256.last_addr", wlog[wlog.size()-1][23:16], 8'hFF);
        else chk("len256.last_addr", 32'hFFFF_FFFF, 8'hFF);

        chk("ready_low_only_in_write", hs_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
